// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-port register file with busy scoreboard.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   re / raddr              per-port read enable and address (port i: bit i,
//                           slice [i*ADDR_W +: ADDR_W])
//   rdata / rbusy           per-port read data and pending-producer flag
//   we0/waddr0/wdata0       writeback port 0
//   we1/waddr1/wdata1       writeback port 1 (wins over port 0 on same address)
//   iss_en / iss_addr       issue: mark destination register busy
//   flush                   clear every busy bit
//   init_done               high once the post-reset zeroing sweep is complete
//
// After reset the array is swept to zero one register per cycle (DEPTH cycles).
// Reads are combinational with write-to-read bypass; port 1 bypass wins.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREAD-1:0]          re,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic                      iss_en,
    input  logic [ADDR_W-1:0]         iss_addr,
    input  logic                      flush,
    output logic                      init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DEPTH-1:0]    busy;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr0_ok;
    logic                wr1_ok;

    // Writes to register 0 are dropped when it is hard-wired to zero.
    assign wr0_ok = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && waddr1 == '0);

    // Control state, sweep counter and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            busy      <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // flush > issue > writeback; a new issue supersedes an
                    // older producer completing in the same cycle.
                    for (int unsigned a = 0; a < DEPTH; a++) begin
                        if (ZERO_REG != 0 && a == 0)
                            busy[a] <= 1'b0;
                        else if (flush)
                            busy[a] <= 1'b0;
                        else if (iss_en && iss_addr == ADDR_W'(a))
                            busy[a] <= 1'b1;
                        else if ((we0 && waddr0 == ADDR_W'(a)) ||
                                 (we1 && waddr1 == ADDR_W'(a)))
                            busy[a] <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Storage array: no reset, contents are defined by the sweep.
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0_ok)
                mem[waddr0] <= wdata0;
            if (wr1_ok)
                mem[waddr1] <= wdata1;
        end
    end

    // Read ports with bypass. Issue in the same cycle does not show in rbusy
    // because busy[] is only updated at the clock edge.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (state == ST_RUN && re[i] && !(ZERO_REG != 0 && ra == '0)) begin
                if (we1 && waddr1 == ra) begin
                    rd = wdata1;
                end else if (we0 && waddr0 == ra) begin
                    rd = wdata0;
                end else begin
                    rd = mem[ra];
                    rb = busy[ra];
                end
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
        assign rbusy[i]                  = rb;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  re = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0 = 1'b0;
    logic [4:0]  waddr0 = '0;
    logic [31:0] wdata0 = '0;
    logic        we1 = 1'b0;
    logic [4:0]  waddr1 = '0;
    logic [31:0] wdata1 = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        flush = 1'b0;
    logic        init_done;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_run;
    int          m_cnt;

    regfile_mp_sb #(
        .DATA_W(32),
        .ADDR_W(5),
        .NREAD(2),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .re(re),
        .raddr(raddr),
        .rdata(rdata),
        .rbusy(rbusy),
        .we0(we0),
        .waddr0(waddr0),
        .wdata0(wdata0),
        .we1(we1),
        .waddr1(waddr1),
        .wdata1(wdata1),
        .iss_en(iss_en),
        .iss_addr(iss_addr),
        .flush(flush),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic void exp_read(input int p, output logic [31:0] d, output logic b);
        logic [4:0] a;
        a = raddr[p*5 +: 5];
        d = 32'h0;
        b = 1'b0;
        if (m_run && re[p] && a != 0) begin
            if (we1 && waddr1 == a)      d = wdata1;
            else if (we0 && waddr0 == a) d = wdata0;
            else begin
                d = m_mem[a];
                b = m_busy[a];
            end
        end
    endfunction

    function automatic void model_edge();
        if (!m_run) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == 32) m_run = 1'b1;
        end else begin
            if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
            for (int a = 0; a < 32; a++) begin
                if (a == 0 || flush)                      m_busy[a] = 1'b0;
                else if (iss_en && iss_addr == a)         m_busy[a] = 1'b1;
                else if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) m_busy[a] = 1'b0;
            end
        end
    endfunction

    task automatic settle();
        logic [31:0] d;
        logic        b;
        #1;
        for (int p = 0; p < 2; p++) begin
            exp_read(p, d, b);
            check($sformatf("rdata%0d", p), rdata[p*32 +: 32], d);
            check($sformatf("rbusy%0d", p), {31'h0, rbusy[p]}, {31'h0, b});
        end
        check("init_done", {31'h0, init_done}, {31'h0, m_run});
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle();
        re = '0; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_run = 1'b0;
        m_cnt = 0;
        for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
        #1;
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_rbusy", {30'h0, rbusy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic randomize_inputs(input bit allow_flush);
        re     = 2'($urandom_range(0, 3));
        raddr  = {rnd_addr(), rnd_addr()};
        we0    = 1'($urandom_range(0, 1));
        waddr0 = rnd_addr();
        wdata0 = $urandom;
        we1    = 1'($urandom_range(0, 1));
        waddr1 = rnd_addr();
        wdata1 = $urandom;
        iss_en = 1'($urandom_range(0, 1));
        iss_addr = rnd_addr();
        flush  = allow_flush && ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        for (int a = 0; a < 32; a++) m_mem[a] = 32'hx;
        #1;
        do_reset();

        // Sweep: reads return 0, writes/issue/flush ignored
        for (int k = 0; k < 32; k++) begin
            randomize_inputs(1'b1);
            re = 2'b11;
            if (k == 10) begin
                we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
                iss_en = 1'b1; iss_addr = 5'd5;
            end
            if (k == 31) check("init_done_before_32", {31'h0, init_done}, 32'h0);
            cycle();
        end
        check("init_done_at_32", {31'h0, init_done}, 32'h1);
        idle();
        re = 2'b01; raddr = {5'd0, 5'd5};
        settle();
        check("reg5_after_init", rdata[31:0], 32'h0);
        check("reg5_busy_after_init", {31'h0, rbusy[0]}, 32'h0);
        advance();

        // Bypass then array read
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF; re = 2'b01; raddr = {5'd0, 5'd3};
        settle();
        check("bypass_we0", rdata[31:0], 32'hDEADBEEF);
        advance();
        we0 = 1'b0;
        settle();
        check("array_reg3", rdata[31:0], 32'hDEADBEEF);
        advance();

        // Dual write collision: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        re = 2'b10; raddr = {5'd7, 5'd0};
        settle();
        check("collide_bypass", rdata[63:32], 32'h22);
        advance();
        idle(); re = 2'b01; raddr = {5'd0, 5'd7};
        settle();
        check("collide_array", rdata[31:0], 32'h22);
        advance();

        // Issue / writeback on reg 9
        iss_en = 1'b1; iss_addr = 5'd9; re = 2'b01; raddr = {5'd0, 5'd9};
        settle();
        check("iss_same_cycle_busy", {31'h0, rbusy[0]}, 32'h0);
        advance();
        iss_en = 1'b0;
        settle();
        check("iss_busy_next", {31'h0, rbusy[0]}, 32'h1);
        advance();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55;
        settle();
        check("wb_bypass_data", rdata[31:0], 32'h55);
        check("wb_bypass_busy", {31'h0, rbusy[0]}, 32'h0);
        advance();
        we0 = 1'b0;
        settle();
        check("wb_cleared_busy", {31'h0, rbusy[0]}, 32'h0);
        advance();

        // Issue beats writeback; flush clears everything
        iss_en = 1'b1; iss_addr = 5'd4; we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hABCD;
        cycle();
        iss_addr = 5'd12; we1 = 1'b0;
        cycle();
        iss_en = 1'b0; re = 2'b11; raddr = {5'd12, 5'd4};
        settle();
        check("iss_beats_wb_busy", {31'h0, rbusy[0]}, 32'h1);
        check("iss_beats_wb_data", rdata[31:0], 32'hABCD);
        check("busy12", {31'h0, rbusy[1]}, 32'h1);
        advance();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        settle();
        check("flush_clears", {30'h0, rbusy}, 32'h0);
        advance();

        // Register 0 hard-wired
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 5'd0;
        re = 2'b01; raddr = {5'd0, 5'd0};
        settle();
        check("reg0_bypass", rdata[31:0], 32'h0);
        advance();
        idle(); re = 2'b11;
        settle();
        check("reg0_data", rdata[31:0], 32'h0);
        check("reg0_busy", {31'h0, rbusy[0]}, 32'h0);
        advance();

        // Randomized run against the model
        for (int k = 0; k < 400; k++) begin
            randomize_inputs(1'b1);
            cycle();
        end

        // Mid-run reset restarts the sweep
        idle();
        check("pre_reset_done", {31'h0, init_done}, 32'h1);
        do_reset();
        for (int k = 0; k < 32; k++) begin
            randomize_inputs(1'b1);
            cycle();
        end
        for (int k = 0; k < 100; k++) begin
            randomize_inputs(1'b1);
            cycle();
        end
        idle(); re = 2'b11; raddr = {5'd31, 5'd1};
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file; the successor of the CPU's 2R/1W regfile.
- Adds N read ports, two prioritised writeback ports, and write-to-read bypass on every port.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) and a post-reset zeroing sweep.
- Sits between decode/issue (reads, busy check, issue) and the writeback stage(s).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NREAD, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- re  in  NREAD  per-port read enable; port i uses bit i.
- raddr  in  NREAD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  read data, same slicing as raddr.
- rbusy  out  NREAD  1 = register read on port i has a pending producer.
- we0 / waddr0 / wdata0  in  1 / ADDR_W / DATA_W  writeback port 0.
- we1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  writeback port 1; higher priority than port 0.
- iss_en / iss_addr  in  1 / ADDR_W  issue: mark the destination register busy.
- flush  in  1  clear all busy bits (pipeline flush).
- init_done  out  1  high once the zeroing sweep is complete.

Behaviour:
- Reset (rst_n low, async):
  - all busy bits cleared; sweep counter = 0; state = INIT; init_done = 0.
  - Array contents are undefined until the sweep completes.
- State INIT:
  - Each cycle writes 0 to reg[cnt] and increments cnt.
  - After writing DEPTH-1 -> state RUN, init_done = 1 from the next cycle; INIT lasts exactly DEPTH cycles.
  - In INIT, rdata = 0 and rbusy = 0 on all ports.
  - we0/we1/iss_en/flush are ignored; no state change other than the sweep.
- State RUN; stays in RUN until rst_n asserts. Reset mid-sweep or mid-run restarts INIT from cnt = 0.
- Write:
  - On a clock edge, weK with a valid address writes wdataK into reg[waddrK].
  - If we0 and we1 target the same address, wdata1 is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency), per port i, in priority order:
  - INIT, or !re[i], or (ZERO_REG and addr 0) -> rdata 0, rbusy 0.
  - else we1 && waddr1 == addr -> wdata1, rbusy 0.
  - else we0 && waddr0 == addr -> wdata0, rbusy 0.
  - else rdata = reg[addr], rbusy = busy[addr].
  - Exception: an iss_en to the same address in the same cycle does not affect rbusy until the next cycle.
- Scoreboard update at each RUN clock edge:
  - busy[a] next = flush ? 0 : (iss_en && iss_addr == a) ? 1 : ((we0 && waddr0 == a) || (we1 && waddr1 == a)) ? 0 : busy[a].
  - Issue beats writeback to the same address (a new producer supersedes the old one).
  - flush beats both issue and writeback; data writes still occur during flush.
  - With ZERO_REG=1, busy[0] is constant 0.
- No errors or backpressure: writes to a non-busy register are legal and clear nothing extra.

Test Plan:
- Reset, then 32 cycles -> init_done rises exactly on cycle 32; every read port returns 0 throughout INIT; we0 to reg 5 during INIT has no effect (reg 5 reads 0 afterwards).
- RUN, NREAD=2: we0 writes reg 3 = 0xDEADBEEF; same cycle raddr port0 = 3 -> rdata0 = 0xDEADBEEF (bypass); next cycle, no write -> still 0xDEADBEEF from the array.
- we0 (reg 7 = 0x11) and we1 (reg 7 = 0x22) together -> same-cycle read gives 0x22; later read gives 0x22.
- iss_en reg 9 -> next cycle rbusy = 1 for a read of 9; we0 reg 9 = 0x55 -> same-cycle read 0x55 with rbusy 0; next cycle busy = 0.
- Same cycle iss_en reg 4 and we1 reg 4 -> busy[4] = 1 afterwards with reg 4 updated; then flush -> all rbusy 0 next cycle.
- Write reg 0 = 0xFFFFFFFF and iss_en reg 0 -> reads of 0 return 0 with rbusy 0; pulse rst_n low mid-RUN -> init_done drops asynchronously and the sweep restarts.
